alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the CPU's combinational 8-bit ALU.
- Executes one operation per START request and registers RESULT, ZERO and CARRY.
- Adds subtract, XOR, shifts, rotate and an iterative shift-add multiplier.
- Reports completion with a BUSY/DONE handshake so the control unit can stall on the multi-cycle multiply.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- MUL_EN, 1, 1 enables MUL; 0 makes the MUL encoding behave as reserved.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset; priority over all other inputs.
- START  input  1  operation request; sampled at a rising edge only when BUSY=0.
- DATA1  input  WIDTH  operand 1 (shift/rotate source).
- DATA2  input  WIDTH  operand 2 (shift/rotate amount, unsigned full value).
- SELECT  input  4  operation code.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  registered, 1 when RESULT==0.
- CARRY  output  1  registered carry/no-borrow flag.
- BUSY  output  1  multiply in progress.
- DONE  output  1  one-cycle pulse per completed operation.

Behaviour:
- Reset values: RESULT=0, ZERO=1, CARRY=0, BUSY=0, DONE=0; FSM state IDLE; iteration counter 0.
- SELECT encoding; all arithmetic is modulo 2^WIDTH:
  - 0000 FWD: RESULT=DATA2.
  - 0001 ADD: DATA1+DATA2.
  - 0010 AND.
  - 0011 OR.
  - 0100 SUB: DATA1-DATA2.
  - 0101 XOR.
  - 0110 SLL.
  - 0111 SRL.
  - 1000 SRA.
  - 1001 ROR.
  - 1010 MUL: low WIDTH bits of the unsigned product.
  - 1011-1111 reserved: RESULT=0.
- CARRY values:
  - ADD: carry-out.
  - SUB: 1 when DATA1>=DATA2 unsigned (no borrow).
  - All other ops: 0.
- Shift/rotate amounts:
  - SLL/SRL with DATA2>=WIDTH give 0.
  - SRA with DATA2>=WIDTH gives all sign bits.
  - ROR uses DATA2 mod WIDTH.
- FSM states: IDLE, MUL.
- IDLE, START=1, non-MUL op:
  - Compute from the current inputs.
  - At that same edge, load RESULT/ZERO/CARRY and set DONE=1; latency 1 cycle.
  - Stay in IDLE; back-to-back STARTs on consecutive cycles are legal and keep DONE high continuously.
- IDLE, START=1, MUL:
  - Latch DATA1/DATA2 into internal operand registers and clear the accumulator.
  - Set BUSY=1 and go to MUL.
  - RESULT holds its previous value during the multiply.
- MUL state:
  - One shift-add iteration per edge, WIDTH iterations total.
  - At the WIDTH-th edge after the START edge: load RESULT/ZERO, set CARRY=0, DONE=1, BUSY=0, return to IDLE.
  - Multiply latency is WIDTH cycles.
- START while BUSY=1 is ignored (not queued). DATA1/DATA2/SELECT changes during BUSY have no effect.
- DONE deasserts on the next edge unless another operation completes at that edge.
- START=0 in IDLE: all outputs hold; DONE=0.
- RESET during MUL aborts the operation: no DONE, outputs take reset values at that edge.
- RESET together with START: RESET wins; the request is dropped.
- ZERO and CARRY change only at the edge where RESULT is loaded.

Test Plan (WIDTH=8):
- ADD, DATA1=0x0A, DATA2=0x02, 1-cycle START → next cycle RESULT=0x0C, DONE=1 for exactly one cycle, ZERO=0, CARRY=0; then FWD → RESULT=0x02.
- ADD 0xF6+0x0A → RESULT=0x00, ZERO=1, CARRY=1.
- SUB 0x02-0x0A → RESULT=0xF8, CARRY=0.
- SUB 0x0A-0x02 → RESULT=0x08, CARRY=1.
- Shifts and rotates on DATA1=0x90:
  - SRA by 3 → 0xF2.
  - SRL by 3 → 0x12.
  - SLL by 9 → 0x00, ZERO=1.
  - ROR 0x81 by 9 → 0xC0.
- MUL 0x0D×0x0B:
  - BUSY high for 8 cycles; DONE on the 8th edge after START; RESULT=0x8F.
  - Change DATA1/DATA2 and pulse START mid-operation → result unchanged, no extra DONE.
  - Then MUL 0x10×0x20 → RESULT=0x00, ZERO=1.
- Reset and reserved op:
  - RESET asserted on the 4th MUL cycle → BUSY=0, DONE never pulses, RESULT=0, ZERO=1.
  - ADD START on the following cycle completes normally.
  - SELECT=1111 → RESULT=0, DONE=1.
- Consecutive STARTs ADD, XOR, OR on 3 back-to-back cycles → RESULT updates each cycle, DONE high for 3 cycles; with MUL_EN=0, SELECT=1010 → RESULT=0 after 1 cycle, BUSY never set.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : clocked ALU, one op per start, iterative shift-add multiplier     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0]       c_op_fwd = 4'b0000;
  localparam logic [3:0]       c_op_add = 4'b0001;
  localparam logic [3:0]       c_op_and = 4'b0010;
  localparam logic [3:0]       c_op_or  = 4'b0011;
  localparam logic [3:0]       c_op_sub = 4'b0100;
  localparam logic [3:0]       c_op_xor = 4'b0101;
  localparam logic [3:0]       c_op_sll = 4'b0110;
  localparam logic [3:0]       c_op_srl = 4'b0111;
  localparam logic [3:0]       c_op_sra = 4'b1000;
  localparam logic [3:0]       c_op_ror = 4'b1001;
  localparam logic [3:0]       c_op_mul = 4'b1010;
  localparam logic [WIDTH-1:0] c_width  = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    c_last   = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_add;
  logic [WIDTH-1:0]   w_rot_amt;
  logic [2*WIDTH-1:0] w_ror2;
  logic               w_big_shift;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_is_mul;

  assign w_add       = {1'b0, data1} + {1'b0, data2};
  assign w_big_shift = (data2 >= c_width);
  assign w_rot_amt   = data2 % c_width;
  assign w_ror2      = {data1, data1} >> w_rot_amt;
  assign w_is_mul    = MUL_EN && (select == c_op_mul);
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (select)
      c_op_fwd: w_res = data2;
      c_op_add: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
      end
      c_op_and: w_res = data1 & data2;
      c_op_or:  w_res = data1 | data2;
      c_op_sub: begin
        w_res   = data1 - data2;
        w_carry = (data1 >= data2);
      end
      c_op_xor: w_res = data1 ^ data2;
      c_op_sll: w_res = w_big_shift ? '0 : (data1 << data2);
      c_op_srl: w_res = w_big_shift ? '0 : (data1 >> data2);
      c_op_sra: w_res = w_big_shift ? {WIDTH{data1[WIDTH-1]}}
                                    : WIDTH'($signed(data1) >>> data2);
      c_op_ror: w_res = w_ror2[WIDTH-1:0];
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_mcand  <= data1;
              r_mplier <= data2;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_carry  <= w_carry;
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // Multiplicand walks left while the multiplier is consumed LSB first.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_carry  <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign carry  = r_carry;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// Directed testbench for alu_seq: one MUL-enabled and one MUL-disabled instance on shared inputs.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data1, data2;
  logic [3:0] select;
  logic [7:0] result, result_nm;
  logic       zero, carry, busy, done;
  logic       zero_nm, carry_nm, busy_nm, done_nm;

  int checks = 0;
  int errors = 0;
  int seen;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .data1(data1), .data2(data2),
    .select(select), .result(result), .zero(zero), .carry(carry),
    .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .start(start), .data1(data1), .data2(data2),
    .select(select), .result(result_nm), .zero(zero_nm), .carry(carry_nm),
    .busy(busy_nm), .done(done_nm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start at the falling edge; returns 1ns after the capturing edge.
  task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    select = sel; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data1 = '0; data2 = '0; select = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_result", result, 8'h00);
    chk("rst_zero",   zero,   1'b1);
    chk("rst_carry",  carry,  1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);

    issue(4'b0001, 8'h0A, 8'h02);
    chk("add_res",   result, 8'h0C);
    chk("add_done",  done,   1'b1);
    chk("add_zero",  zero,   1'b0);
    chk("add_carry", carry,  1'b0);
    tick();
    chk("add_done_drop", done,   1'b0);
    chk("idle_hold",     result, 8'h0C);

    issue(4'b0000, 8'h55, 8'h02);
    chk("fwd_res", result, 8'h02);

    issue(4'b0001, 8'hF6, 8'h0A);
    chk("addc_res",   result, 8'h00);
    chk("addc_zero",  zero,   1'b1);
    chk("addc_carry", carry,  1'b1);

    issue(4'b0100, 8'h02, 8'h0A);
    chk("subb_res",   result, 8'hF8);
    chk("subb_carry", carry,  1'b0);
    issue(4'b0100, 8'h0A, 8'h02);
    chk("sub_res",    result, 8'h08);
    chk("sub_carry",  carry,  1'b1);
    issue(4'b0100, 8'h37, 8'h37);
    chk("sub_eq_zero",  zero,  1'b1);
    chk("sub_eq_carry", carry, 1'b1);

    issue(4'b0010, 8'hF0, 8'h3C);
    chk("and_res", result, 8'h30);
    issue(4'b1000, 8'h90, 8'h03);
    chk("sra_res", result, 8'hF2);
    issue(4'b1000, 8'h90, 8'h20);
    chk("sra_big", result, 8'hFF);
    issue(4'b0111, 8'h90, 8'h03);
    chk("srl_res", result, 8'h12);
    issue(4'b0110, 8'h90, 8'h09);
    chk("sll_big",  result, 8'h00);
    chk("sll_zero", zero,   1'b1);
    issue(4'b0110, 8'h90, 8'h02);
    chk("sll_res", result, 8'h40);
    issue(4'b1001, 8'h81, 8'h09);
    chk("ror_res", result, 8'hC0);
    issue(4'b1001, 8'h81, 8'h00);
    chk("ror0_res", result, 8'h81);

    // MUL 0x0D * 0x0B, with a disturbing start mid-operation
    issue(4'b1010, 8'h0D, 8'h0B);
    chk("mul_busy_0", busy,   1'b1);
    chk("mul_done_0", done,   1'b0);
    chk("mul_hold",   result, 8'h81);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; data1 = 8'hFF; data2 = 8'hFF; select = 4'b0001;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < 8) begin
        chk("mul_busy", busy, 1'b1);
        chk("mul_done_early", done, 1'b0);
      end
    end
    chk("mul_done",  done,   1'b1);
    chk("mul_busy8", busy,   1'b0);
    chk("mul_res",   result, 8'h8F);
    chk("mul_zero",  zero,   1'b0);
    chk("mul_carry", carry,  1'b0);
    tick();
    chk("mul_no_extra_done", done, 1'b0);

    issue(4'b1010, 8'h10, 8'h20);
    for (int k = 1; k <= 8; k++) tick();
    chk("mul2_done", done,   1'b1);
    chk("mul2_res",  result, 8'h00);
    chk("mul2_zero", zero,   1'b1);

    // Reset aborts a multiply in progress
    issue(4'b0001, 8'h01, 8'h02);
    issue(4'b1010, 8'h0D, 8'h0B);
    tick(); tick();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("abort_busy",   busy,   1'b0);
    chk("abort_result", result, 8'h00);
    chk("abort_zero",   zero,   1'b1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_no_done", seen, 0);

    issue(4'b0001, 8'h0A, 8'h02);
    chk("post_rst_add", result, 8'h0C);
    chk("post_rst_done", done, 1'b1);

    // Reset together with start drops the request
    @(negedge clk);
    reset = 1'b1; start = 1'b1; select = 4'b0000; data2 = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start_res",  result, 8'h00);
    chk("rst_start_done", done,   1'b0);

    issue(4'b0000, 8'h00, 8'h5A);
    issue(4'b1111, 8'h12, 8'h34);
    chk("rsv_res",  result, 8'h00);
    chk("rsv_done", done,   1'b1);
    chk("rsv_zero", zero,   1'b1);

    // Back-to-back starts
    @(negedge clk);
    start = 1'b1; select = 4'b0001; data1 = 8'h33; data2 = 8'h11;
    tick();
    chk("b2b_add", result, 8'h44);
    chk("b2b_done1", done, 1'b1);
    @(negedge clk); select = 4'b0101;
    tick();
    chk("b2b_xor", result, 8'h22);
    chk("b2b_done2", done, 1'b1);
    @(negedge clk); select = 4'b0011;
    tick();
    chk("b2b_or", result, 8'h33);
    chk("b2b_done3", done, 1'b1);
    start = 1'b0;
    tick();
    chk("b2b_done_drop", done, 1'b0);

    // MUL encoding on the MUL-disabled instance is reserved
    issue(4'b1010, 8'h0D, 8'h0B);
    chk("nomul_res",  result_nm, 8'h00);
    chk("nomul_done", done_nm,   1'b1);
    chk("nomul_busy", busy_nm,   1'b0);
    chk("mul_en_busy", busy,     1'b1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy_nm) seen++;
      tick();
    end
    chk("nomul_never_busy", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
